seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Reads the segment and digit-select lines of a multiplexed, scanned seven-segment display and recovers the hex nibble shown on each digit. It is the decode-side counterpart of the nibble-to-segment encoder. It sits between the display driver outputs, or external display pins, and the checking and logging logic. Patterns are accepted only after they are stable for a programmable dwell, and changes are reported over a valid/ready event stream.

## Interface
- DIGITS, default 4: number of scanned digits; must be ≥ 2.
- STABLE_CYC, default 4: consecutive identical samples required to accept a pattern; must be ≥ 2.
- clk  in  1  single clock; all state is in this domain.
- rst_n  in  1  asynchronous, active-low reset.
- SEG  in  8  segment lines {dp,g,f,e,d,c,b,a}, active-high; asynchronous to clk.
- DIG  in  DIGITS  digit enables, active-high, one-hot when valid; asynchronous to clk.
- VALUE  out  4*DIGITS  last accepted nibble per digit; digit i occupies VALUE[4i+3:4i].
- VLD  out  DIGITS  digit has been accepted at least once since reset.
- ERR  out  DIGITS  last accepted pattern for that digit was not a legal hex glyph.
- DP  out  DIGITS  dp bit of the last accepted pattern.
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts the event.
- ev_digit  out  clog2(DIGITS)  event digit index.
- ev_nibble  out  4  event nibble; 0 when ev_err is 1.
- ev_err  out  1  event pattern illegal.
- ovf  out  1  sticky flag: an event was dropped.
- ovf_clr  in  1  synchronous clear of ovf.

## Operation
- SEG and DIG each pass through a 2-flop synchronizer, giving the sampled vector S = {DIG, SEG}.
- Legal glyphs on SEG[6:0]:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→27
  - 8→7F, 9→6F, A→77, B→7C, C→39, D→5E, E→79, F→71
  - Any other value is illegal: ERR is set and the nibble is 0.
  - The dp bit never affects legality.
- FSM states: IDLE, TRACK, LOCKED.
  - IDLE: S's DIG field is not one-hot (zero or multiple bits set). Counter held at 0.
  - Any change in S moves to TRACK with counter=0 if DIG is one-hot, otherwise to IDLE.
  - TRACK: counter increments each cycle S is unchanged. When the counter reaches STABLE_CYC-1, the pattern is accepted and the FSM moves to LOCKED.
  - LOCKED: holds until S changes. The same dwell is never accepted twice.
- Accept action for digit i:
  - Write VALUE[i], ERR[i] and DP[i]; set VLD[i].
  - Generate an event only if VLD[i] was 0, or if the nibble or ERR differs from the stored value. A dp-only change updates DP[i] without generating an event.
- Event buffer: one entry.
  - Loads when it is empty, or when it is being accepted this cycle (ev_valid & ev_ready).
  - If an event arrives while the entry is full and not being accepted, the new event is dropped and ovf is set. The held event is unchanged.
  - ovf_clr clears ovf. If ovf_clr and a drop occur in the same cycle, ovf remains set.
  - ev_* fields are stable while ev_valid=1 and ev_ready=0.

## Timing
- Reset values: VALUE=0, VLD=0, ERR=0, DP=0, ev_valid=0, ev_digit=0, ev_nibble=0, ev_err=0, ovf=0. Synchronizers are cleared, FSM is IDLE, counter is 0.
- Latency: inputs changed before edge 0 and then held update VALUE, VLD, ERR, DP and ev_valid at edge STABLE_CYC+2.
- A change in S before the counter reaches STABLE_CYC-1 restarts the count; nothing is updated.
- ev_valid falls on the edge after ev_ready=1, unless a new event loads on that same edge.
- Reset asserted mid-dwell or mid-handshake clears everything immediately. After release, the next acceptance needs a full STABLE_CYC dwell.
- Counter width is clog2(STABLE_CYC) and it saturates; it never wraps.

## Structure
- Package seg7_pkg:
  - the 16 glyph constants
  - segment bit-position constants
  - SEG_INVALID = 8'hC9
  - FSM state enum
- Sub-module seg7_to_nibble: combinational SEG[6:0] → {err, nibble[3:0]}. It is reusable by the bench scoreboard.
- Top level contains:
  - synchronizers
  - change detect
  - FSM and counter
  - one-hot check and index encoder
  - per-digit register file
  - event buffer

## Test plan
- Reset, then hold DIG=0001, SEG=0x5B (STABLE_CYC=4): at edge 6, VALUE[3:0]=2, VLD=0001, ev_valid=1, ev_digit=0, ev_nibble=2.
- Scan digits 0–3 with 7F/27/77/71, 8 cycles each, ev_ready=1: four events with nibbles 8, 7, A, F. A second identical scan produces no events.
- Hold SEG=0xC9 on digit 1: ERR[1]=1, ev_err=1, ev_nibble=0. Then 0x06 with dp set (0x86): nibble 1, ERR[1]=0, DP[1]=1.
- Change SEG after 2 stable cycles, and drive DIG=0011 for 10 cycles: neither produces an acceptance or an event.
- ev_ready=0 and two digits change: the first event is held, the second is dropped, ovf=1. Then ev_ready=1 with a simultaneous new event: the new event loads with no overflow. ovf_clr then clears ovf.
- Assert rst_n=0 mid-dwell and while ev_valid=1: all outputs are 0 immediately. After release, a held pattern reappears only after 6 edges.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared constants for the seven-segment scan decoder:
//     - segment bit positions within the {dp,g,f,e,d,c,b,a} byte
//     - the 16 legal hex glyphs on SEG[6:0]
//     - SEG_INVALID, a pattern that never decodes to a legal glyph
//     - scan FSM state type
// -----------------------------------------------------------------------------
package seg7_pkg;

    // Segment bit positions
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Legal hex glyphs on SEG[6:0]
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h27;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    localparam logic [7:0] SEG_INVALID = 8'hC9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,  // DIG not one-hot
        ST_TRACK  = 2'd1,  // counting a stable dwell
        ST_LOCKED = 2'd2   // dwell accepted, waiting for S to change
    } scan_state_t;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder_if
//   Valid/ready event stream carrying one decoded digit update.
//     ev_valid  : event available (master -> slave)
//     ev_ready  : consumer accepts the event (slave -> master)
//     ev_digit  : digit index of the event
//     ev_nibble : decoded nibble, 0 when ev_err is set
//     ev_err    : accepted pattern was not a legal glyph
// -----------------------------------------------------------------------------
interface seg7_scan_decoder_if #(
    parameter int DIGITS = 4
);
    localparam int IDX_W = $clog2(DIGITS);

    logic             ev_valid;
    logic             ev_ready;
    logic [IDX_W-1:0] ev_digit;
    logic [3:0]       ev_nibble;
    logic             ev_err;

    modport master (
        output ev_valid,
        output ev_digit,
        output ev_nibble,
        output ev_err,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_digit,
        input  ev_nibble,
        input  ev_err,
        output ev_ready
    );

endinterface

// File: rtl/seg7_to_nibble.sv
// -----------------------------------------------------------------------------
// seg7_to_nibble
//   Combinational glyph decoder.
//     seg    in  7  segment lines {g,f,e,d,c,b,a}
//     err    out 1  pattern is not a legal hex glyph
//     nibble out 4  decoded value, 0 when err is set
// -----------------------------------------------------------------------------
module seg7_to_nibble
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       err,
    output logic [3:0] nibble
);

    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        err    = 1'b0;
        nibble = 4'h0;
        case (seg)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//   Watches the segment/digit lines of a scanned seven-segment display and
//   recovers the nibble shown on each digit once the pattern has been stable
//   for STABLE_CYC samples. Changes are reported over a one-entry event
//   stream.
//
//   clk, rst_n : clock, asynchronous active-low reset
//   SEG        : {dp,g,f,e,d,c,b,a}, asynchronous to clk
//   DIG        : digit enables, one-hot when valid, asynchronous to clk
//   VALUE      : last accepted nibble per digit (digit i at [4i+3:4i])
//   VLD        : digit accepted at least once since reset
//   ERR        : last accepted pattern for the digit was illegal
//   DP         : dp bit of the last accepted pattern
//   ev         : event stream (master side)
//   ovf        : sticky, an event was dropped
//   ovf_clr    : synchronous clear of ovf
// -----------------------------------------------------------------------------
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            SEG,
    input  logic [DIGITS-1:0]     DIG,
    output logic [4*DIGITS-1:0]   VALUE,
    output logic [DIGITS-1:0]     VLD,
    output logic [DIGITS-1:0]     ERR,
    output logic [DIGITS-1:0]     DP,
    seg7_scan_decoder_if.master   ev,
    output logic                  ovf,
    input  logic                  ovf_clr
);

    localparam int S_W   = DIGITS + 8;
    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

    // ---------------------------------------------------------------- sync
    logic [S_W-1:0] sync1_q, sync2_q, prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source; blocking here would collapse
    // the synchronizer chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {DIG, SEG};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    logic [DIGITS-1:0] s_dig;
    logic [7:0]        s_seg;
    logic              change;
    logic              one_hot;

    assign s_dig   = sync2_q[S_W-1:8];
    assign s_seg   = sync2_q[7:0];
    assign change  = (sync2_q != prev_q);
    assign one_hot = $onehot(s_dig);

    // One-hot to index: OR of the indices of set bits is exact for one-hot
    // input; the result is only used when one_hot is true.
    logic [IDX_W-1:0] s_idx;
    always_comb begin
        s_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (s_dig[i]) s_idx = s_idx | IDX_W'(i);
        end
    end

    // ---------------------------------------------------------------- FSM
    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (change) begin
            // Any new sample restarts the dwell from scratch.
            state_d = one_hot ? ST_TRACK : ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE:   cnt_d = '0;
                ST_TRACK: begin
                    if (cnt_q == CNT_MAX) begin
                        accept  = 1'b1;
                        state_d = ST_LOCKED;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_LOCKED: ;  // counter stays saturated until S changes
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- decode
    logic       dec_err;
    logic [3:0] dec_nibble;

    seg7_to_nibble u_dec (
        .seg    (s_seg[SEG_G:SEG_A]),
        .err    (dec_err),
        .nibble (dec_nibble)
    );

    // ---------------------------------------------------------------- regfile
    logic [DIGITS-1:0][3:0] value_q;
    logic [DIGITS-1:0]      vld_q, err_q, dp_q;
    logic                   ev_new;

    // A dp-only change refreshes DP but is not reported as an event.
    assign ev_new = accept && (!vld_q[s_idx] ||
                               (value_q[s_idx] != dec_nibble) ||
                               (err_q[s_idx]   != dec_err));

    // NOTE: the per-digit storage is reset like any other flop because its
    // contents are directly visible on VALUE/ERR/DP and must read 0 after
    // reset; it is small enough that this costs nothing worth saving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            vld_q   <= '0;
            err_q   <= '0;
            dp_q    <= '0;
        end else if (accept) begin
            value_q[s_idx] <= dec_nibble;
            err_q[s_idx]   <= dec_err;
            dp_q[s_idx]    <= s_seg[SEG_DP];
            vld_q[s_idx]   <= 1'b1;
        end
    end

    assign VALUE = value_q;
    assign VLD   = vld_q;
    assign ERR   = err_q;
    assign DP    = dp_q;

    // ---------------------------------------------------------------- events
    logic             ev_valid_q;
    logic [IDX_W-1:0] ev_digit_q;
    logic [3:0]       ev_nibble_q;
    logic             ev_err_q;
    logic             ev_load, ev_drop;

    // The single entry may be refilled on the same edge it is consumed.
    assign ev_load = ev_new && (!ev_valid_q || ev.ev_ready);
    assign ev_drop = ev_new && ev_valid_q && !ev.ev_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_valid_q  <= 1'b0;
            ev_digit_q  <= '0;
            ev_nibble_q <= '0;
            ev_err_q    <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            if (ev_load) begin
                ev_valid_q  <= 1'b1;
                ev_digit_q  <= s_idx;
                ev_nibble_q <= dec_nibble;
                ev_err_q    <= dec_err;
            end else if (ev.ev_ready) begin
                ev_valid_q  <= 1'b0;
            end
            // A drop wins over a simultaneous clear.
            if (ev_drop)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    assign ev.ev_valid  = ev_valid_q;
    assign ev.ev_digit  = ev_digit_q;
    assign ev.ev_nibble = ev_nibble_q;
    assign ev.ev_err    = ev_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//   Self-checking bench for seg7_scan_decoder. The reference model thinks in
//   terms of "held display patterns": a pattern held for at least
//   STABLE_CYC+1 input cycles on a one-hot digit is accepted once; accepted
//   values land in a per-digit table and produce an event when new or changed.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    localparam int DIGITS     = 4;
    localparam int STABLE_CYC = 4;
    localparam int IDX_W      = $clog2(DIGITS);

    localparam logic [6:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [IDX_W-1:0] digit;
        logic [3:0]       nibble;
        logic             err;
    } ev_t;

    logic                clk     = 1'b0;
    logic                rst_n   = 1'b0;
    logic [7:0]          seg     = 8'h00;
    logic [DIGITS-1:0]   dig     = '0;
    logic                ovf_clr = 1'b0;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   vld, err, dp;
    logic                ovf;

    seg7_scan_decoder_if #(.DIGITS(DIGITS)) ev_if ();

    always #5 clk = ~clk;

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYC(STABLE_CYC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SEG     (seg),
        .DIG     (dig),
        .VALUE   (value),
        .VLD     (vld),
        .ERR     (err),
        .DP      (dp),
        .ev      (ev_if),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------ model
    logic [3:0]        m_value [DIGITS];
    logic              m_vld   [DIGITS];
    logic              m_err   [DIGITS];
    logic              m_dp    [DIGITS];
    ev_t               exp_q [$];
    ev_t               got_q [$];
    logic [DIGITS-1:0] cur_dig;
    logic [7:0]        cur_seg;
    int                cur_len;
    bit                cur_done;

    // Every completed handshake is recorded just before the edge it happens on.
    ev_t seen;
    always @(negedge clk) begin
        if (rst_n && ev_if.ev_valid && ev_if.ev_ready) begin
            seen.digit  = ev_if.ev_digit;
            seen.nibble = ev_if.ev_nibble;
            seen.err    = ev_if.ev_err;
            got_q.push_back(seen);
        end
    end

    function automatic void ref_decode(input logic [6:0] s, output logic e, output logic [3:0] n);
        e = 1'b1;
        n = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (GLYPHS[k] == s) begin
                e = 1'b0;
                n = 4'(k);
            end
        end
    endfunction

    function automatic int idx_of(input logic [DIGITS-1:0] d);
        int r = 0;
        for (int k = 0; k < DIGITS; k++) if (d[k]) r = k;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DIGITS; k++) begin
            m_value[k] = 4'h0;
            m_vld[k]   = 1'b0;
            m_err[k]   = 1'b0;
            m_dp[k]    = 1'b0;
        end
        cur_dig  = '0;
        cur_seg  = 8'h00;
        cur_len  = 0;
        cur_done = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic model_accept(input int idx, input logic [7:0] s);
        logic       e;
        logic [3:0] n;
        ev_t        x;
        ref_decode(s[6:0], e, n);
        if (!m_vld[idx] || m_value[idx] != n || m_err[idx] != e) begin
            x.digit  = IDX_W'(idx);
            x.nibble = n;
            x.err    = e;
            exp_q.push_back(x);
        end
        m_value[idx] = n;
        m_err[idx]   = e;
        m_dp[idx]    = s[7];
        m_vld[idx]   = 1'b1;
    endtask

    // Present a display pattern; an identical pattern extends the current dwell.
    task automatic begin_seg(input logic [DIGITS-1:0] d, input logic [7:0] s);
        dig = d;
        seg = s;
        if ({d, s} != {cur_dig, cur_seg}) begin
            cur_len  = 0;
            cur_done = 1'b0;
        end
        cur_dig = d;
        cur_seg = s;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cur_len++;
            if ($countones(cur_dig) == 1 && !cur_done && cur_len >= STABLE_CYC + 1) begin
                cur_done = 1'b1;
                model_accept(idx_of(cur_dig), cur_seg);
            end
        end
    endtask

    // Blank the display, let pending events drain, then compare everything.
    task automatic scoreboard_compare(input string tag);
        logic [4*DIGITS-1:0] x_value;
        logic [DIGITS-1:0]   x_vld, x_err, x_dp;
        begin_seg('0, 8'h00);
        tick(STABLE_CYC + 3);
        for (int k = 0; k < DIGITS; k++) begin
            x_value[4*k +: 4] = m_value[k];
            x_vld[k] = m_vld[k];
            x_err[k] = m_err[k];
            x_dp[k]  = m_dp[k];
        end
        n_checks++; if (value !== x_value) begin n_fail++; $display("FAIL %s.value: got %h expected %h", tag, value, x_value); end
        n_checks++; if (vld !== x_vld) begin n_fail++; $display("FAIL %s.vld: got %b expected %b", tag, vld, x_vld); end
        n_checks++; if (err !== x_err) begin n_fail++; $display("FAIL %s.err: got %b expected %b", tag, err, x_err); end
        n_checks++; if (dp !== x_dp) begin n_fail++; $display("FAIL %s.dp: got %b expected %b", tag, dp, x_dp); end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s.event_count: got %0d expected %0d", tag, got_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < got_q.size(); k++) begin
                n_checks++;
                if (got_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL %s.event[%0d]: got %h expected %h", tag, k, got_q[k], exp_q[k]);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        ev_if.ev_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({value, vld, err, dp, ev_if.ev_valid, ev_if.ev_digit, ev_if.ev_nibble, ev_if.ev_err, ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_held: outputs %h %b %b %b ev %b/%0d/%h/%b ovf %b, all expected 0",
                     value, vld, err, dp, ev_if.ev_valid, ev_if.ev_digit, ev_if.ev_nibble, ev_if.ev_err, ovf);
        end
        rst_n = 1'b1;
        tick(3);
        n_checks++;
        if ({value, vld, err, dp, ev_if.ev_valid, ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: outputs %h %b %b %b ev %b ovf %b, all expected 0",
                     value, vld, err, dp, ev_if.ev_valid, ovf);
        end
    endtask

    task automatic test_latency();
        begin_seg(4'b0001, 8'h5B);
        tick(STABLE_CYC + 2);
        n_checks++;
        if (vld !== 4'b0000 || ev_if.ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: vld %b ev_valid %b, expected 0000/0", vld, ev_if.ev_valid);
        end
        tick(1);
        n_checks++;
        if (value[3:0] !== 4'h2 || vld !== 4'b0001) begin
            n_fail++;
            $display("FAIL latency_regs: value0 %h vld %b, expected 2/0001", value[3:0], vld);
        end
        n_checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_digit !== 2'd0 || ev_if.ev_nibble !== 4'h2 || ev_if.ev_err !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_event: ev %b/%0d/%h/%b, expected 1/0/2/0",
                     ev_if.ev_valid, ev_if.ev_digit, ev_if.ev_nibble, ev_if.ev_err);
        end
        scoreboard_compare("latency");
    endtask

    task automatic test_scan();
        logic [7:0] pats [4] = '{8'h7F, 8'h27, 8'h77, 8'h71};
        logic [3:0] nibs [4] = '{4'h8, 4'h7, 4'hA, 4'hF};
        for (int k = 0; k < DIGITS; k++) begin
            begin_seg(DIGITS'(1 << k), pats[k]);
            tick(8);
        end
        begin_seg('0, 8'h00);
        tick(6);
        n_checks++;
        if (got_q.size() != 4) begin
            n_fail++;
            $display("FAIL scan1_count: got %0d events expected 4", got_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (got_q[k].nibble !== nibs[k] || got_q[k].digit !== IDX_W'(k)) begin
                    n_fail++;
                    $display("FAIL scan1_event%0d: got digit %0d nibble %h expected %0d/%h",
                             k, got_q[k].digit, got_q[k].nibble, k, nibs[k]);
                end
            end
        end
        scoreboard_compare("scan1");
        for (int k = 0; k < DIGITS; k++) begin
            begin_seg(DIGITS'(1 << k), pats[k]);
            tick(8);
        end
        begin_seg('0, 8'h00);
        tick(6);
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL scan2_count: got %0d events expected 0", got_q.size());
        end
        scoreboard_compare("scan2");
    endtask

    task automatic test_illegal();
        begin_seg(4'b0010, 8'hC9);
        tick(8);
        begin_seg('0, 8'h00);
        tick(6);
        n_checks++;
        if (err[1] !== 1'b1 || value[7:4] !== 4'h0) begin
            n_fail++;
            $display("FAIL illegal_regs: err1 %b value1 %h, expected 1/0", err[1], value[7:4]);
        end
        n_checks++;
        if (got_q.size() != 1 || got_q[0].err !== 1'b1 || got_q[0].nibble !== 4'h0 || got_q[0].digit !== 2'd1) begin
            n_fail++;
            $display("FAIL illegal_event: %0d events, first %h, expected one with digit 1 err 1 nibble 0",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
        end
        scoreboard_compare("illegal");
        begin_seg(4'b0010, 8'h86);
        tick(8);
        begin_seg('0, 8'h00);
        tick(6);
        n_checks++;
        if (value[7:4] !== 4'h1 || err[1] !== 1'b0 || dp[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL dp_glyph: value1 %h err1 %b dp1 %b, expected 1/0/1", value[7:4], err[1], dp[1]);
        end
        scoreboard_compare("dp_glyph");
        begin_seg(4'b0010, 8'h06);
        tick(8);
        begin_seg('0, 8'h00);
        tick(6);
        n_checks++;
        if (dp[1] !== 1'b0 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL dp_only: dp1 %b events %0d, expected 0/0", dp[1], got_q.size());
        end
        scoreboard_compare("dp_only");
    endtask

    task automatic test_no_accept();
        begin_seg(4'b0100, 8'h66); tick(2);
        begin_seg(4'b0100, 8'h6D); tick(2);
        begin_seg(4'b0100, 8'h7D); tick(2);
        begin_seg(4'b0011, 8'h3F); tick(10);
        begin_seg('0, 8'h00);
        tick(6);
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL no_accept_events: got %0d events expected 0", got_q.size());
        end
        scoreboard_compare("no_accept");
    endtask

    task automatic test_overflow();
        ev_if.ev_ready = 1'b0;
        begin_seg(4'b0100, 8'h06); tick(8);
        begin_seg(4'b1000, 8'h5B); tick(8);
        begin_seg('0, 8'h00);      tick(4);
        n_checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_digit !== 2'd2 || ev_if.ev_nibble !== 4'h1 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drop: ev %b/%0d/%h ovf %b, expected 1/2/1 ovf 1",
                     ev_if.ev_valid, ev_if.ev_digit, ev_if.ev_nibble, ovf);
        end
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        n_checks++;
        if (ovf !== 1'b0 || ev_if.ev_valid !== 1'b1 || ev_if.ev_digit !== 2'd2) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf %b ev %b/%0d, expected 0 and held 1/2", ovf, ev_if.ev_valid, ev_if.ev_digit);
        end
        // Consume the held event on exactly the edge a new one is accepted.
        begin_seg(4'b0001, 8'h4F);
        tick(STABLE_CYC + 2);
        ev_if.ev_ready = 1'b1;
        tick(1);
        n_checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_digit !== 2'd0 || ev_if.ev_nibble !== 4'h3 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL load_on_accept: ev %b/%0d/%h ovf %b, expected 1/0/3 ovf 0",
                     ev_if.ev_valid, ev_if.ev_digit, ev_if.ev_nibble, ovf);
        end
        tick(2);
        n_checks++;
        if (ev_if.ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_falls: ev_valid %b expected 0", ev_if.ev_valid);
        end
        exp_q.delete();
        got_q.delete();
        scoreboard_compare("overflow");
    endtask

    task automatic test_reset_mid();
        ev_if.ev_ready = 1'b0;
        begin_seg(4'b0100, 8'h7F); tick(8);
        begin_seg(4'b0010, 8'h4F); tick(3);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({value, vld, err, dp, ev_if.ev_valid, ev_if.ev_digit, ev_if.ev_nibble, ev_if.ev_err, ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: outputs %h %b %b %b ev %b/%0d/%h/%b ovf %b, all expected 0",
                     value, vld, err, dp, ev_if.ev_valid, ev_if.ev_digit, ev_if.ev_nibble, ev_if.ev_err, ovf);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin_seg(4'b0010, 8'h4F);
        tick(STABLE_CYC + 2);
        n_checks++;
        if (vld !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_redwell_early: vld %b expected 0000", vld);
        end
        tick(1);
        n_checks++;
        if (vld !== 4'b0010 || value[7:4] !== 4'h3 || ev_if.ev_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_redwell: vld %b value1 %h ev_valid %b, expected 0010/3/1",
                     vld, value[7:4], ev_if.ev_valid);
        end
        ev_if.ev_ready = 1'b1;
        scoreboard_compare("reset_mid");
    endtask

    task automatic test_random();
        logic [DIGITS-1:0] d;
        logic [7:0]        s;
        ev_if.ev_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) < 8) d = DIGITS'(1 << $urandom_range(0, DIGITS - 1));
            else                          d = DIGITS'($urandom);
            if ($urandom_range(0, 3) != 0) s = {1'($urandom), GLYPHS[$urandom_range(0, 15)]};
            else                           s = 8'($urandom);
            begin_seg(d, s);
            tick($urandom_range(1, 10));
        end
        scoreboard_compare("random");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_scan();
        test_illegal();
        test_no_accept();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
